// File: rtl/led_mmio_pkg.sv
// Shared constants, types and helpers for the LED MMIO register block.
package led_mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OFF_W  = 4;

  localparam logic [OFF_W-1:0] OFF_DATA = 4'h0;
  localparam logic [OFF_W-1:0] OFF_SET  = 4'h4;
  localparam logic [OFF_W-1:0] OFF_CLR  = 4'h8;
  localparam logic [OFF_W-1:0] OFF_WCNT = 4'hC;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // One bus request beat as seen at the accept point.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Expand byte enables to a full bit mask.
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/led_mmio_reg_sat_counter.sv
// Parameterised-width saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones, clear has priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/led_mmio_reg.sv
// Memory-mapped LED status register with set/clear aliases and change counter.
module led_mmio_reg
  import led_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk_sys,
  input  logic              rst_sys,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] LEDS,
  output logic              leds_update
);

  state_t            state;
  state_t            state_nx;
  req_t              req;
  logic              accept;
  logic              addr_err;
  logic              store_hit;
  logic              data_change;
  logic [OFF_W-1:0]  offset;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] data_nx;
  logic [DATA_W-1:0] load_data;
  logic [CNT_W-1:0]  cnt;

  assign req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // Only one outstanding request: accept strictly from IDLE.
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Decode: 16-byte window at BASE_ADDR, word-aligned only.
  assign offset   = req.addr[OFF_W-1:0];
  assign addr_err = (req.addr[ADDR_W-1:OFF_W] != BASE_ADDR[ADDR_W-1:OFF_W])
                    || (req.addr[1:0] != 2'b00);
  assign mask     = be_to_mask(req.be);

  // Next DATA value for a store to each alias.
  always_comb begin
    data_nx = LEDS;
    case (offset)
      OFF_DATA: data_nx = (LEDS & ~mask) | (req.wdata & mask);
      OFF_SET:  data_nx = LEDS | (req.wdata & mask);
      OFF_CLR:  data_nx = LEDS & ~(req.wdata & mask);
      default:  data_nx = LEDS;
    endcase
  end

  // Load data: WCNT reads the counter, every other alias reads DATA.
  always_comb begin
    load_data = LEDS;
    if (offset == OFF_WCNT) begin
      load_data = {{(DATA_W-CNT_W){1'b0}}, cnt};
    end
  end

  // Stores to WCNT are silently dropped; only real value changes count.
  assign store_hit   = accept && req.we && !addr_err && (offset != OFF_WCNT);
  assign data_change = store_hit && (data_nx != LEDS);

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state: IDLE -> RESP on accept, RESP -> IDLE on rsp_ready.
  always_comb begin
    state_nx = state;
    if (state == IDLE) begin
      if (accept) begin
        state_nx = RESP;
      end
    end else begin
      if (rsp_ready) begin
        state_nx = IDLE;
      end
    end
  end

  // Response channel and LED data registers.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      LEDS        <= '0;
      leds_update <= 1'b0;
    end else begin
      leds_update <= data_change;
      if (data_change) begin
        LEDS <= data_nx;
      end
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_err   <= addr_err;
        rsp_rdata <= (!req.we && !addr_err) ? load_data : '0;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Change counter, cleared by reset.
  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk_sys),
    .clr   (rst_sys),
    .inc   (data_change),
    .count (cnt)
  );

endmodule

// File: tb/tb_led_mmio_reg.sv
// Self-checking bench for led_mmio_reg: directed table, random traffic, corners.
module tb_led_mmio_reg;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] LEDS;
  logic        leds_update;

  logic        sc_clr;
  logic        sc_inc;
  logic [3:0]  sc_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state of the peripheral.
  logic [31:0] data_m;
  logic [15:0] cnt_m;

  always #5 clk_sys = ~clk_sys;

  led_mmio_reg #(.BASE_ADDR(BASE)) dut (
    .clk_sys     (clk_sys),
    .rst_sys     (rst_sys),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .LEDS        (LEDS),
    .leds_update (leds_update)
  );

  // Narrow standalone counter so saturation is reachable quickly.
  sat_counter #(.W(4)) u_sc (
    .clk   (clk_sys),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .count (sc_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one accepted request.
  task automatic model_step(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic err, output logic [31:0] rdata,
                            output logic chg);
    logic [31:0] m;
    logic [31:0] nd;
    logic [31:0] off;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
    off   = addr - BASE;
    err   = !((addr >= BASE) && (off < 32'd16) && (addr[1:0] == 2'b00));
    nd    = data_m;
    rdata = 32'h0;
    if (!err) begin
      if (!we) begin
        rdata = (off == 32'd12) ? {16'h0, cnt_m} : data_m;
      end else begin
        case (off)
          32'd0:   nd = (data_m & ~m) | (wdata & m);
          32'd4:   nd = data_m | (wdata & m);
          32'd8:   nd = data_m & ~(wdata & m);
          default: nd = data_m;
        endcase
      end
    end
    chg = (nd != data_m);
    if (chg) begin
      data_m = nd;
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end
  endtask

  // One full transaction; called at posedge+#1 with the block idle.
  task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int stall, input string tag,
                          output logic [31:0] got_rdata, output logic got_err);
    logic        e_err;
    logic [31:0] e_rdata;
    logic        e_chg;
    chk({tag, ":req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = (stall == 0);
    model_step(we, addr, wdata, be, e_err, e_rdata, e_chg);
    @(posedge clk_sys); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    chk({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ":rsp_err"}, 32'(rsp_err), 32'(e_err));
    chk({tag, ":rsp_rdata"}, rsp_rdata, e_rdata);
    chk({tag, ":leds"}, LEDS, data_m);
    chk({tag, ":leds_update"}, 32'(leds_update), 32'(e_chg));
    chk({tag, ":req_ready_busy"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk_sys); #1;
      chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, rsp_rdata, e_rdata);
      chk({tag, ":hold_err"}, 32'(rsp_err), 32'(e_err));
      chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ":hold_pulse"}, 32'(leds_update), 32'd0);
      if (i == stall - 1) rsp_ready = 1'b1;
    end
    @(posedge clk_sys); #1;
    chk({tag, ":done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":done_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ":done_pulse"}, 32'(leds_update), 32'd0);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stall;
    logic [31:0] exp_leds;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] addr;
    logic [31:0] wd;
    int          sel;

    vecs[0]  = '{1'b1, BASE + 32'h0,  32'hAAAAAAA0, 4'hF, 0, 32'hAAAAAAA0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, BASE + 32'hC,  32'h0,        4'hF, 0, 32'hAAAAAAA0, 1'b0, 32'h1};
    vecs[2]  = '{1'b1, BASE + 32'h0,  32'h0,        4'hF, 0, 32'h00000000, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, BASE + 32'h0,  32'hFFFFFFFF, 4'h1, 0, 32'h000000FF, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, BASE + 32'h4,  32'h0000000F, 4'hF, 0, 32'h000000FF, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, BASE + 32'hC,  32'h0,        4'hF, 1, 32'h000000FF, 1'b0, 32'h3};
    vecs[6]  = '{1'b1, BASE + 32'h8,  32'h000000F0, 4'hF, 0, 32'h0000000F, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, BASE + 32'h4,  32'h0,        4'hF, 0, 32'h0000000F, 1'b0, 32'h0000000F};
    vecs[8]  = '{1'b0, BASE + 32'h14, 32'h0,        4'hF, 0, 32'h0000000F, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, BASE + 32'h2,  32'hFFFFFFFF, 4'hF, 0, 32'h0000000F, 1'b1, 32'h0};
    vecs[10] = '{1'b0, BASE - 32'h4,  32'h0,        4'hF, 0, 32'h0000000F, 1'b1, 32'h0};
    vecs[11] = '{1'b1, BASE + 32'hC,  32'h12345678, 4'hF, 0, 32'h0000000F, 1'b0, 32'h0};
    vecs[12] = '{1'b0, BASE + 32'hC,  32'h0,        4'hF, 0, 32'h0000000F, 1'b0, 32'h4};
    vecs[13] = '{1'b1, BASE + 32'h0,  32'hDEDEDEDE, 4'hF, 0, 32'hDEDEDEDE, 1'b0, 32'h0};
    vecs[14] = '{1'b1, BASE + 32'h0,  32'h55555555, 4'h0, 0, 32'hDEDEDEDE, 1'b0, 32'h0};
    vecs[15] = '{1'b0, BASE + 32'h0,  32'h0,        4'hF, 3, 32'hDEDEDEDE, 1'b0, 32'hDEDEDEDE};
    vecs[16] = '{1'b0, BASE + 32'h8,  32'h0,        4'hF, 0, 32'hDEDEDEDE, 1'b0, 32'hDEDEDEDE};
    vecs[17] = '{1'b0, BASE + 32'hC,  32'h0,        4'hF, 2, 32'hDEDEDEDE, 1'b0, 32'h5};

    rst_sys   = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = BASE;
    req_wdata = 32'hFFFFFFFF;
    req_be    = 4'hF;
    rsp_ready = 1'b0;
    sc_clr    = 1'b1;
    sc_inc    = 1'b0;
    data_m    = 32'h0;
    cnt_m     = 16'h0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset:leds", LEDS, 32'h0);
    chk("reset:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset:rsp_err", 32'(rsp_err), 32'd0);
    chk("reset:rsp_rdata", rsp_rdata, 32'h0);
    chk("reset:leds_update", 32'(leds_update), 32'd0);
    chk("reset:req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rst_sys   = 1'b0;
    @(posedge clk_sys); #1;

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      transact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].stall,
               $sformatf("vec%0d", i), rd, er);
      chk($sformatf("vec%0d:tbl_leds", i), LEDS, vecs[i].exp_leds);
      chk($sformatf("vec%0d:tbl_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d:tbl_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Random traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)      addr = BASE + 32'(4 * $urandom_range(0, 3));
      else if (sel == 7) addr = BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(1, 3));
      else if (sel == 8) addr = BASE + 32'h10 + 32'(4 * $urandom_range(0, 15));
      else               addr = $urandom;
      wd = $urandom;
      transact(1'($urandom_range(0, 2) != 0), addr, wd, 4'($urandom), int'($urandom_range(0, 2)),
               $sformatf("rnd%0d", t), rd, er);
    end

    // Many alternating value-changing stores, then read the counter.
    for (int t = 0; t < 300; t++) begin
      transact(1'b1, BASE, (t % 2 == 0) ? 32'hBBBBBBB0 : 32'hCCCCCCC0, 4'hF, 0, "alt", rd, er);
    end
    transact(1'b0, BASE + 32'hC, 32'h0, 4'hF, 0, "alt_wcnt", rd, er);

    // Saturation behaviour on a 4-bit instance of the counter.
    sc_clr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      sc_inc = 1'b1;
      @(posedge clk_sys); #1;
      chk($sformatf("sat:step%0d", i), 32'(sc_count), (i > 15) ? 32'd15 : 32'(i));
    end
    sc_inc = 1'b0;
    @(posedge clk_sys); #1;
    chk("sat:hold", 32'(sc_count), 32'd15);
    sc_clr = 1'b1;
    sc_inc = 1'b1;
    @(posedge clk_sys); #1;
    chk("sat:clear", 32'(sc_count), 32'd0);
    sc_clr = 1'b0;
    sc_inc = 1'b0;

    // Reset asserted while a store response is pending.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = BASE;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    rsp_ready = 1'b0;
    @(posedge clk_sys); #1;
    chk("rstmid:leds_before", LEDS, 32'h12345678);
    chk("rstmid:valid_before", 32'(rsp_valid), 32'd1);
    rst_sys   = 1'b1;
    req_valid = 1'b1;
    req_wdata = 32'hFFFF0000;
    @(posedge clk_sys); #1;
    chk("rstmid:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid:leds", LEDS, 32'h0);
    chk("rstmid:req_ready", 32'(req_ready), 32'd1);
    @(posedge clk_sys); #1;
    chk("rstmid:ignored_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid:ignored_leds", LEDS, 32'h0);
    rst_sys   = 1'b0;
    req_valid = 1'b0;
    data_m    = 32'h0;
    cnt_m     = 16'h0;
    @(posedge clk_sys); #1;
    transact(1'b0, BASE + 32'hC, 32'h0, 4'hF, 0, "post_rst_wcnt", rd, er);
    chk("post_rst_wcnt:value", rd, 32'h0);
    transact(1'b1, BASE + 32'h4, 32'h00000081, 4'hF, 1, "post_rst_set", rd, er);
    chk("post_rst_set:leds", LEDS, 32'h00000081);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
